// File: rtl/uart_avm_pkg.sv
// Shared definitions for the RS232 Avalon-MM arbiter slice.
// Holds the slave register map, the status bit positions, the default bus
// widths and the arbiter state type.
package uart_avm_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  // Word-offset byte addresses of the RS232 slave registers
  localparam logic [4:0] RX_BASE     = 5'd0;
  localparam logic [4:0] TX_BASE     = 5'd4;
  localparam logic [4:0] STATUS_BASE = 5'd8;

  // Bit positions inside the status word
  localparam int TX_OK_BIT = 6;
  localparam int RX_OK_BIT = 7;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/uart_avm_arbiter_rr_arbiter2.sv
// Two-request round-robin picker (purely combinational).
// Ports:
//   req        : request vector, bit i = port i requesting
//   last_grant : index of the port served most recently
//   gnt_valid  : at least one request present
//   gnt_idx    : chosen port; on a tie the port other than last_grant wins
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    if (req == 2'b11) gnt_idx = ~last_grant;
    else              gnt_idx = req[1];
  end

endmodule

// File: rtl/uart_avm_arbiter.sv
// Shares one RS232 Avalon-MM slave between two single-word requesters
// (port 0: image/RX reader, port 1: command/TX writer) using round-robin.
// Ports:
//   avm_clk / avm_rst_n     : clock, asynchronous active-low reset
//   r0_* / r1_*             : requester-side Avalon-MM slave interfaces
//   avm_*                   : master interface toward the RS232 slave
//   err_clr                 : clears the sticky error flags
//   err_timeout             : sticky, stall watchdog forced a completion
//   err_protocol            : sticky, requester broke the handshake
module uart_avm_arbiter
  import uart_avm_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = 1024
) (
  input  logic              avm_clk,
  input  logic              avm_rst_n,
  input  logic [ADDR_W-1:0] r0_address,
  input  logic              r0_read,
  input  logic              r0_write,
  input  logic [DATA_W-1:0] r0_writedata,
  output logic [DATA_W-1:0] r0_readdata,
  output logic              r0_waitrequest,
  input  logic [ADDR_W-1:0] r1_address,
  input  logic              r1_read,
  input  logic              r1_write,
  input  logic [DATA_W-1:0] r1_writedata,
  output logic [DATA_W-1:0] r1_readdata,
  output logic              r1_waitrequest,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest,
  input  logic              err_clr,
  output logic              err_timeout,
  output logic              err_protocol
);

  localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  arb_state_e        state;
  logic              grant;
  logic              last_grant;
  logic [CNT_W-1:0]  wait_cnt;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;

  logic [1:0]        req;
  logic              pick_valid;
  logic              pick_idx;
  logic              g_read;
  logic              g_write;
  logic              g_req;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic              in_grant;
  logic              wd_hit;
  logic              done;
  logic              timeout;
  logic              abort;
  logic              ack;
  logic              both_strobes;
  logic [DATA_W-1:0] ret_data;

  assign req = {r1_read | r1_write, r0_read | r0_write};

  rr_arbiter2 u_rr (
    .req        (req),
    .last_grant (last_grant),
    .gnt_valid  (pick_valid),
    .gnt_idx    (pick_idx)
  );

  always_comb begin
    g_read  = grant ? r1_read      : r0_read;
    g_write = grant ? r1_write     : r0_write;
    g_addr  = grant ? r1_address   : r0_address;
    g_wdata = grant ? r1_writedata : r0_writedata;
    g_req   = g_read | g_write;

    in_grant = (state == S_GRANT);
    wd_hit   = (MAX_WAIT > 0) && (wait_cnt == CNT_W'(MAX_WAIT - 1));
    // Dropping both strobes takes precedence over any slave response.
    abort    = in_grant & ~g_req;
    done     = in_grant & g_req & ~avm_waitrequest;
    timeout  = in_grant & g_req & avm_waitrequest & wd_hit;
    ack      = done | timeout;
    ret_data = timeout ? '0 : avm_readdata;

    both_strobes = (r0_read & r0_write) | (r1_read & r1_write);
  end

  // Slave side: read+write together is issued as a write.
  always_comb begin
    avm_read      = in_grant & g_read & ~g_write;
    avm_write     = in_grant & g_write;
    avm_address   = in_grant ? g_addr  : '0;
    avm_writedata = in_grant ? g_wdata : '0;

    r0_waitrequest = ~(ack & ~grant);
    r1_waitrequest = ~(ack & grant);
    // Completion data is forwarded combinationally and also captured so the
    // requester keeps seeing it afterwards.
    r0_readdata    = (ack & ~grant) ? ret_data : rdata0;
    r1_readdata    = (ack & grant)  ? ret_data : rdata1;
  end

  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      state        <= S_IDLE;
      grant        <= 1'b0;
      last_grant   <= 1'b1;
      wait_cnt     <= '0;
      rdata0       <= '0;
      rdata1       <= '0;
      err_timeout  <= 1'b0;
      err_protocol <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            grant    <= pick_idx;
            state    <= S_GRANT;
            wait_cnt <= '0;
          end
        end
        S_GRANT: begin
          if (ack | abort) begin
            state      <= S_IDLE;
            last_grant <= grant;
          end else if (avm_waitrequest) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (ack) begin
        if (grant) rdata1 <= ret_data;
        else       rdata0 <= ret_data;
      end

      if (timeout)      err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;

      if (abort | both_strobes) err_protocol <= 1'b1;
      else if (err_clr)         err_protocol <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_avm_arbiter.sv
// Self-checking bench for uart_avm_arbiter: directed scenarios plus
// randomized Avalon traffic, all compared against a transaction-level model.
module tb_uart_avm_arbiter;
  import uart_avm_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int MW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] r0_address, r1_address, avm_address;
  logic          r0_read, r0_write, r1_read, r1_write;
  logic [DW-1:0] r0_writedata, r1_writedata, r0_readdata, r1_readdata;
  logic          r0_waitrequest, r1_waitrequest;
  logic          avm_read, avm_write, avm_waitrequest;
  logic [DW-1:0] avm_writedata, avm_readdata;
  logic          err_clr, err_timeout, err_protocol;

  always #5 clk = ~clk;

  uart_avm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .avm_clk(clk), .avm_rst_n(rst_n),
    .r0_address(r0_address), .r0_read(r0_read), .r0_write(r0_write),
    .r0_writedata(r0_writedata), .r0_readdata(r0_readdata), .r0_waitrequest(r0_waitrequest),
    .r1_address(r1_address), .r1_read(r1_read), .r1_write(r1_write),
    .r1_writedata(r1_writedata), .r1_readdata(r1_readdata), .r1_waitrequest(r1_waitrequest),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .err_clr(err_clr), .err_timeout(err_timeout), .err_protocol(err_protocol)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model: is a transfer in flight, for whom, how long stalled
  bit            m_busy;
  int            m_who, m_last, m_stall;
  logic [DW-1:0] m_rd [2];
  bit            m_to, m_pe;

  // Expected outputs for the current cycle and pending model update
  logic          e_rd, e_wr;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic [1:0]    e_wait;
  logic [DW-1:0] e_rdata [2];
  bit            n_busy, n_set_to, n_set_pe, n_clr, n_done;
  int            n_who, n_last, n_stall, n_port;
  logic [DW-1:0] n_data;

  // Observed outputs from the last sampled cycle
  logic          obs_w0, obs_w1, obs_aw, obs_to;
  logic [DW-1:0] obs_rd0, obs_awd;
  logic [AW-1:0] obs_aaddr;

  bit pend [2];

  task automatic model_reset();
    m_busy = 0; m_who = 0; m_last = 1; m_stall = 0;
    m_rd[0] = '0; m_rd[1] = '0; m_to = 0; m_pe = 0; e_wait = '1;
  endtask

  task automatic model_eval();
    bit rdp [2], wrp [2], rq [2];
    logic [AW-1:0] ad [2];
    logic [DW-1:0] wd [2];
    int w;
    rdp[0] = r0_read; wrp[0] = r0_write; ad[0] = r0_address; wd[0] = r0_writedata;
    rdp[1] = r1_read; wrp[1] = r1_write; ad[1] = r1_address; wd[1] = r1_writedata;
    for (int i = 0; i < 2; i++) rq[i] = rdp[i] | wrp[i];
    e_rd = 0; e_wr = 0; e_addr = '0; e_wdata = '0; e_wait = '1;
    e_rdata[0] = m_rd[0]; e_rdata[1] = m_rd[1];
    n_busy = m_busy; n_who = m_who; n_last = m_last; n_stall = m_stall;
    n_set_to = 0; n_done = 0; n_port = 0; n_data = '0; n_clr = err_clr;
    n_set_pe = (rdp[0] & wrp[0]) | (rdp[1] & wrp[1]);
    if (!m_busy) begin
      if (rq[0] || rq[1]) begin
        n_busy = 1; n_stall = 0;
        if (rq[0] && rq[1]) n_who = 1 - m_last;
        else                n_who = rq[1] ? 1 : 0;
      end
    end else begin
      w = m_who;
      e_addr = ad[w]; e_wdata = wd[w];
      if (!rq[w]) begin
        n_busy = 0; n_last = w; n_set_pe = 1;
      end else begin
        e_rd = rdp[w] & ~wrp[w];
        e_wr = wrp[w];
        if (!avm_waitrequest || m_stall == MW - 1) begin
          n_done = 1; n_port = w;
          n_data = avm_waitrequest ? '0 : avm_readdata;
          if (avm_waitrequest) n_set_to = 1;
          e_wait[w] = 1'b0; e_rdata[w] = n_data;
          n_busy = 0; n_last = w;
        end else begin
          n_stall = m_stall + 1;
        end
      end
    end
  endtask

  task automatic model_advance();
    m_busy = n_busy; m_who = n_who; m_last = n_last; m_stall = n_stall;
    if (n_done) m_rd[n_port] = n_data;
    m_to = n_set_to ? 1'b1 : (n_clr ? 1'b0 : m_to);
    m_pe = n_set_pe ? 1'b1 : (n_clr ? 1'b0 : m_pe);
  endtask

  task automatic step();
    @(negedge clk);
    model_eval();
    check("avm_read",      avm_read,       e_rd);
    check("avm_write",     avm_write,      e_wr);
    check("avm_address",   avm_address,    e_addr);
    check("avm_writedata", avm_writedata,  e_wdata);
    check("r0_wait",       r0_waitrequest, e_wait[0]);
    check("r1_wait",       r1_waitrequest, e_wait[1]);
    check("r0_readdata",   r0_readdata,    e_rdata[0]);
    check("r1_readdata",   r1_readdata,    e_rdata[1]);
    check("err_timeout",   err_timeout,    m_to);
    check("err_protocol",  err_protocol,   m_pe);
    obs_w0 = r0_waitrequest; obs_w1 = r1_waitrequest; obs_rd0 = r0_readdata;
    obs_aw = avm_write; obs_awd = avm_writedata; obs_aaddr = avm_address;
    obs_to = err_timeout;
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic set_port(input int p, input logic rd, input logic wr,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin r0_read = rd; r0_write = wr; r0_address = a; r0_writedata = d; end
    else        begin r1_read = rd; r1_write = wr; r1_address = a; r1_writedata = d; end
  endtask

  task automatic drive_random(input int stall_pct, input int abort_pct);
    logic [AW-1:0] a;
    int op;
    for (int p = 0; p < 2; p++) begin
      if (pend[p] && e_wait[p] == 1'b0) pend[p] = 0;
      if (pend[p] && $urandom_range(99) < abort_pct) begin
        pend[p] = 0;
        set_port(p, 1'b0, 1'b0, '0, '0);
      end else if (!pend[p]) begin
        if ($urandom_range(99) < 60) begin
          pend[p] = 1;
          case ($urandom_range(2))
            0:       a = RX_BASE;
            1:       a = TX_BASE;
            default: a = STATUS_BASE;
          endcase
          op = $urandom_range(9);
          set_port(p, op < 4 || op == 9, op >= 4, a, $urandom);
        end else begin
          set_port(p, 1'b0, 1'b0, '0, '0);
        end
      end
    end
    avm_waitrequest = ($urandom_range(99) < stall_pct);
    avm_readdata    = $urandom;
    err_clr         = ($urandom_range(99) < 5);
  endtask

  task automatic idle_inputs();
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    avm_waitrequest = 1'b0; avm_readdata = '0; err_clr = 1'b0;
  endtask

  initial begin
    int order [$];
    int k;
    bit seen;

    idle_inputs();
    model_reset();
    #12;
    check("rst_avm_read", avm_read, 1'b0);
    check("rst_avm_addr", avm_address, '0);
    check("rst_r0_wait",  r0_waitrequest, 1'b1);
    check("rst_r1_wait",  r1_waitrequest, 1'b1);
    check("rst_r0_rdata", r0_readdata, '0);
    check("rst_errs",     {err_timeout, err_protocol}, 2'b00);
    @(posedge clk); #1 rst_n = 1'b1;

    // Both ports request together continuously: port 0 first, then alternate
    set_port(0, 1'b1, 1'b0, RX_BASE, '0);
    set_port(1, 1'b0, 1'b1, TX_BASE, 32'h41);
    for (int i = 0; i < 16; i++) begin
      step();
      if (obs_w0 == 1'b0) order.push_back(0);
      if (obs_w1 == 1'b0) order.push_back(1);
      if (obs_aw) begin
        check("tx_wdata", obs_awd, 32'h41);
        check("tx_addr",  obs_aaddr, TX_BASE);
      end
    end
    check("rr_count", order.size(), 8);
    foreach (order[i]) check("rr_order", order[i], i % 2);
    idle_inputs();
    step(); step();

    // Status read: slave stalls 3 grant cycles, then returns 0x80
    set_port(0, 1'b1, 1'b0, STATUS_BASE, '0);
    avm_readdata = 32'h80;
    seen = 0;
    for (k = 1; k <= 20 && !seen; k++) begin
      avm_waitrequest = (k < 5);
      step();
      if (obs_w0 == 1'b0) begin
        seen = 1;
        check("status_lat",   k, 5);
        check("status_rdata", obs_rd0, 32'h80);
      end
    end
    check("status_done", seen, 1'b1);
    idle_inputs();
    step();
    check("status_one_pulse", obs_w0, 1'b1);

    // Watchdog: slave never responds
    set_port(0, 1'b1, 1'b0, RX_BASE, '0);
    avm_waitrequest = 1'b1; avm_readdata = 32'hDEAD_BEEF;
    seen = 0;
    for (k = 1; k <= 40 && !seen; k++) begin
      step();
      if (obs_w0 == 1'b0) begin
        seen = 1;
        check("wd_lat",   k, 17);
        check("wd_rdata", obs_rd0, '0);
      end
    end
    check("wd_done", seen, 1'b1);
    avm_waitrequest = 1'b0; avm_readdata = 32'h1234;
    seen = 0;
    for (k = 1; k <= 10 && !seen; k++) begin
      step();
      if (obs_w0 == 1'b0) seen = 1;
    end
    check("wd_after_done", seen, 1'b1);
    check("wd_sticky", obs_to, 1'b1);
    idle_inputs();
    err_clr = 1'b1; step();
    err_clr = 1'b0; step();
    check("wd_cleared", obs_to, 1'b0);

    // r1 read+write together (tie, r1 wins since r0 went last), then aborts
    set_port(0, 1'b1, 1'b0, RX_BASE, '0);
    set_port(1, 1'b1, 1'b1, TX_BASE, 32'h55);
    avm_waitrequest = 1'b1;
    step(); step();
    set_port(1, 1'b0, 1'b0, '0, '0);
    step();
    avm_waitrequest = 1'b0; avm_readdata = 32'h77;
    seen = 0;
    for (k = 1; k <= 10 && !seen; k++) begin
      step();
      if (obs_w1 == 1'b0) check("abort_no_r1_pulse", obs_w1, 1'b1);
      if (obs_w0 == 1'b0) seen = 1;
    end
    check("abort_r0_next", seen, 1'b1);

    // Async reset in the middle of a stalled grant
    set_port(0, 1'b1, 1'b0, RX_BASE, '0);
    set_port(1, 1'b0, 1'b1, TX_BASE, 32'h99);
    avm_waitrequest = 1'b1;
    step(); step(); step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_avm_rd",  avm_read, 1'b0);
    check("arst_avm_wr",  avm_write, 1'b0);
    check("arst_waits",   {r0_waitrequest, r1_waitrequest}, 2'b11);
    check("arst_errs",    {err_timeout, err_protocol}, 2'b00);
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    avm_waitrequest = 1'b0;
    seen = 0;
    for (k = 1; k <= 10 && !seen; k++) begin
      step();
      if (obs_w1 == 1'b0) check("arst_first_port", 1, 0);
      if (obs_w0 == 1'b0) seen = 1;
    end
    check("arst_r0_first", seen, 1'b1);

    // Randomized traffic: moderate stalls, then heavy stalls to hit the watchdog
    idle_inputs();
    pend[0] = 0; pend[1] = 0;
    step(); step();
    for (int i = 0; i < 400; i++) begin drive_random(40, 2); step(); end
    for (int i = 0; i < 300; i++) begin drive_random(97, 1); step(); end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/uart_avm_arbiter.md
Name: uart_avm_arbiter

Overview:
- Shares the single RS232 Avalon-MM slave between two single-word Avalon-MM requesters: port 0 (image/RX reader) and port 1 (command/TX writer).
- Grants one requester at a time using round-robin.
- Passes the granted transaction through to the slave and returns readdata and completion to the granted requester only.
- Adds a stall watchdog and sticky error flags so a hung slave or misbehaving requester cannot deadlock the video path.

Parameters:
ADDR_W, 5, Avalon address width (word-offset byte addresses 0/4/8 used).
DATA_W, 32, Avalon data width.
MAX_WAIT, 1024, max GRANT cycles with slave waitrequest high before forced completion; 0 disables the watchdog.

Ports:
avm_clk  in  1  block clock
avm_rst_n  in  1  asynchronous active-low reset
r0_address  in  ADDR_W  requester 0 address
r0_read  in  1  requester 0 read strobe
r0_write  in  1  requester 0 write strobe
r0_writedata  in  DATA_W  requester 0 write data
r0_readdata  out  DATA_W  requester 0 read data
r0_waitrequest  out  1  requester 0 stall
r1_address / r1_read / r1_write / r1_writedata / r1_readdata / r1_waitrequest  same widths and directions as port 0, for requester 1
avm_address  out  ADDR_W  to slave
avm_read  out  1  to slave
avm_write  out  1  to slave
avm_writedata  out  DATA_W  to slave
avm_readdata  in  DATA_W  from slave
avm_waitrequest  in  1  from slave
err_clr  in  1  clears sticky errors
err_timeout  out  1  sticky: watchdog fired
err_protocol  out  1  sticky: requester protocol violation

Behaviour:
- Clock and reset: one clock, avm_clk. Reset avm_rst_n is asynchronous, active-low.
- Reset values:
  - state = S_IDLE; last_grant = 1, so port 0 wins the first tie.
  - avm_read = avm_write = 0; avm_address = 0; avm_writedata = 0.
  - r0/r1_waitrequest = 1; r0/r1_readdata = 0.
  - err_timeout = err_protocol = 0; wait_cnt = 0.
- Request definition: req_i = ri_read | ri_write.
  - Read and write asserted together is treated as a write and sets err_protocol.
- S_IDLE:
  - Slave strobes low; both requester waitrequests high.
  - If any req_i: pick with round-robin (prefer port != last_grant when both request).
  - Register grant; next state S_GRANT; wait_cnt = 0.
- S_GRANT (combinational pass-through):
  - avm_address/read/write/writedata = granted requester's signals.
  - Non-granted waitrequest = 1.
  - Granted waitrequest = avm_waitrequest.
  - Granted readdata = avm_readdata when completing, else held.
- Normal completion: avm_waitrequest = 0 in S_GRANT.
  - Exactly one cycle of granted waitrequest = 0.
  - Next state S_IDLE; last_grant = grant.
- Latency: one arbitration cycle. A transaction is never issued in the same cycle it is first seen. There is one idle cycle between back-to-back transactions.
- Watchdog (MAX_WAIT > 0):
  - wait_cnt increments each S_GRANT cycle with avm_waitrequest = 1.
  - In the cycle where avm_waitrequest = 1 and wait_cnt == MAX_WAIT-1: forced completion.
    - Granted waitrequest = 0; readdata = 0.
    - err_timeout set; next S_IDLE; last_grant updated.
  - Counter width: clog2(MAX_WAIT+1).
- Protocol abort: granted requester drops both strobes in S_GRANT before completion.
  - Next S_IDLE; no completion pulse; err_protocol set; last_grant updated.
- Sticky errors:
  - err_clr = 1 clears both flags next edge.
  - If set and clear occur in the same cycle, set wins.
- Async reset mid-transaction: all outputs go to reset values immediately. Any in-flight slave access is abandoned.
- Requesters must hold address/data stable while waitrequest = 1 (Avalon rule). The arbiter does not re-register them.

Decomposition:
- Package uart_avm_pkg:
  - RX_BASE = 0, TX_BASE = 4, STATUS_BASE = 8.
  - TX_OK_BIT = 6, RX_OK_BIT = 7.
  - ADDR_W/DATA_W defaults.
  - typedef enum {S_IDLE, S_GRANT} arb_state_e.
- Sub-module rr_arbiter2: two-request round-robin picker.
  - Inputs: req[1:0], last_grant.
  - Outputs: gnt_valid, gnt_idx.
  - Combinational, reused by later multi-port blocks.

Test Plan:
- Reset, then r0_read and r1_write rise together:
  - r0 granted first; avm_address = r0_address.
  - r1_waitrequest stays 1 until r0 completes, then r1 is served after one idle cycle.
- r0 read of STATUS_BASE (8), slave waitrequest high 3 cycles then low with readdata 0x80:
  - r0_readdata = 0x80 in completion cycle; r0_waitrequest low exactly 1 cycle.
  - Total 5 cycles from request to completion.
- Both ports requesting continuously for 8 transactions:
  - Grant order 0,1,0,1,...; 4 completions each; r1_write data 0x41 reaches avm_writedata with avm_address = 4.
- MAX_WAIT = 16, slave holds waitrequest high:
  - Forced completion on 16th GRANT cycle; r0_readdata = 0; err_timeout = 1.
  - Next transaction proceeds normally; err_clr pulse clears err_timeout.
- r1 asserts read and write together:
  - Treated as write; err_protocol = 1.
  - r1 drops strobes mid-grant: return to S_IDLE with no waitrequest-low pulse; r0 served next.
- Assert avm_rst_n = 0 during a stalled grant:
  - avm_read/avm_write = 0 and both waitrequests = 1 without waiting for a clock edge.
  - After release, port 0 wins the first tie.
